final_soc_mem_loader: RTL and testbench

Avalon-MM master that sits directly upstream of the SoC's 4-word × 32-bit single-port on-chip memory. It accepts a byte stream (valid/ready), packs the bytes little-endian into 32-bit words and writes them with byte enables. On request it reads the whole memory back out as a 32-bit word stream. The memory has no waitrequest, commits writes on the clock edge, and returns read data the cycle after the address is presented.

---
 rtl/final_soc_mem_pkg.sv | 30 +++
 rtl/final_soc_mem_loader_if.sv | 25 ++
 rtl/final_soc_byte_packer.sv | 52 +++++
 rtl/final_soc_mem_loader.sv | 190 +++++++++++++++++++
 tb/tb_final_soc_mem_loader.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/final_soc_mem_pkg.sv
// Shared types, sizes and byte-enable helper for the memory loader.
package final_soc_mem_pkg;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LANES   = WORD_W / BYTE_W;
  localparam int unsigned CNT_W   = $clog2(LANES);
  localparam int unsigned LANE_SH = $clog2(BYTE_W);
  localparam int unsigned MASK_W  = LANES + 1;

  localparam logic [LANES-1:0] BE_FULL = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA,
    RD_OUT
  } state_e;

  // Byte enables covering lanes 0..byte_cnt (the lane being accepted included).
  function automatic logic [LANES-1:0] be_from_count(input logic [CNT_W-1:0] byte_cnt);
    logic [MASK_W-1:0] mask;
    mask = (MASK_W'(1) << (32'(byte_cnt) + 32'd1)) - MASK_W'(1);
    return mask[LANES-1:0];
  endfunction

endpackage

// File: rtl/final_soc_mem_loader_if.sv
// Avalon-MM bus between the loader (master) and the on-chip memory (slave).
interface final_soc_mem_loader_if;
  import final_soc_mem_pkg::*;

  logic [ADDR_W-1:0] mem_address;
  logic [LANES-1:0]  mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [WORD_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [WORD_W-1:0] mem_readdata;

  modport master (
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport slave (
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/final_soc_byte_packer.sv
// Little-endian byte packer: pack register, lane counter and byte enables.
module final_soc_byte_packer
  import final_soc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic              clear,
  input  logic [BYTE_W-1:0] in_data,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic [WORD_W-1:0] word_c,
  output logic [LANES-1:0]  be_c
);

  logic [WORD_W-1:0] pack_q, pack_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W+LANE_SH-1:0] shamt;

  assign byte_cnt = byte_cnt_q;

  // Pack register with the incoming byte merged into lane byte_cnt; upper lanes are always clear.
  always_comb begin
    shamt  = {byte_cnt_q, {LANE_SH{1'b0}}};
    word_c = pack_q | (WORD_W'(in_data) << shamt);
    be_c   = (byte_cnt_q == CNT_W'(LANES - 1)) ? BE_FULL : be_from_count(byte_cnt_q);
  end

  // Next pack/count: clear after the word is written, otherwise absorb accepted bytes.
  always_comb begin
    pack_d     = pack_q;
    byte_cnt_d = byte_cnt_q;
    if (clear) begin
      pack_d     = '0;
      byte_cnt_d = '0;
    end else if (accept) begin
      pack_d     = word_c;
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end
  end

  // Pack register and lane counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pack_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      pack_q     <= pack_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/final_soc_mem_loader.sv
// Byte-stream loader and word read-back master for the 4-word on-chip memory.
module final_soc_mem_loader
  import final_soc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic              load_done,
  output logic              overrun,
  input  logic              rd_start,
  output logic              rd_busy,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  final_soc_mem_loader_if.master mem
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              last_q, last_d;
  logic              wrapped_q, wrapped_d;
  logic              overrun_q, overrun_d;
  logic              load_done_q, load_done_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [LANES-1:0]  mem_be_q, mem_be_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [WORD_W-1:0] mem_wd_q, mem_wd_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic              rd_take_c, in_ready_c, accept_c, pack_clear_c, rd_busy_c;
  logic [CNT_W-1:0]  byte_cnt;
  logic [WORD_W-1:0] word_c;
  logic [LANES-1:0]  be_c;

  final_soc_byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .accept   (accept_c),
    .clear    (pack_clear_c),
    .in_data  (in_data),
    .byte_cnt (byte_cnt),
    .word_c   (word_c),
    .be_c     (be_c)
  );

  // Read-back request beats a byte in the same IDLE cycle, and only between words.
  assign rd_take_c    = (state_q == IDLE) && rd_start && (byte_cnt == '0);
  assign in_ready_c   = (state_q == IDLE) && !reset && !rd_take_c;
  assign accept_c     = in_valid && in_ready_c;
  assign pack_clear_c = (state_q == WRITE);
  assign rd_busy_c    = (state_q == RD_ADDR) || (state_q == RD_DATA) || (state_q == RD_OUT);

  assign in_ready           = in_ready_c;
  assign rd_busy            = rd_busy_c;
  assign load_done          = load_done_q;
  assign overrun            = overrun_q;
  assign out_data           = out_data_q;
  assign out_valid          = out_valid_q;
  assign out_last           = out_last_q;
  assign mem.mem_address    = mem_address_q;
  assign mem.mem_byteenable = mem_be_q;
  assign mem.mem_chipselect = mem_cs_q;
  assign mem.mem_write      = mem_we_q;
  assign mem.mem_writedata  = mem_wd_q;
  assign mem.mem_clken      = 1'b1;

  // Next state, address counters and registered bus/stream outputs.
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    last_d        = last_q;
    wrapped_d     = wrapped_q;
    overrun_d     = overrun_q;
    load_done_d   = 1'b0;
    mem_address_d = '0;
    mem_be_d      = '0;
    mem_cs_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_wd_d      = '0;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;

    case (state_q)
      IDLE: begin
        if (rd_take_c) begin
          state_d       = RD_ADDR;
          rd_addr_d     = '0;
          mem_cs_d      = 1'b1;
          mem_address_d = '0;
        end else if (accept_c) begin
          if (wrapped_q) overrun_d = 1'b1;
          if (in_last || (byte_cnt == CNT_W'(LANES - 1))) begin
            state_d       = WRITE;
            last_d        = in_last;
            mem_cs_d      = 1'b1;
            mem_we_d      = 1'b1;
            mem_address_d = wr_addr_q;
            mem_wd_d      = word_c;
            mem_be_d      = be_c;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        last_d  = 1'b0;
        if (last_q) begin
          wr_addr_d   = '0;
          wrapped_d   = 1'b0;
          load_done_d = 1'b1;
          overrun_d   = 1'b0;
        end else begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (wr_addr_q == ADDR_W'(DEPTH - 1)) wrapped_d = 1'b1;
        end
      end
      RD_ADDR: begin
        state_d = RD_DATA;
      end
      RD_DATA: begin
        state_d     = RD_OUT;
        out_data_d  = mem.mem_readdata;
        out_last_d  = (rd_addr_q == ADDR_W'(DEPTH - 1));
        out_valid_d = 1'b1;
      end
      RD_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = IDLE;
          end else begin
            state_d       = RD_ADDR;
            rd_addr_d     = rd_addr_q + ADDR_W'(1);
            mem_cs_d      = 1'b1;
            mem_address_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      last_q        <= 1'b0;
      wrapped_q     <= 1'b0;
      overrun_q     <= 1'b0;
      load_done_q   <= 1'b0;
      mem_address_q <= '0;
      mem_be_q      <= '0;
      mem_cs_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wd_q      <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      last_q        <= last_d;
      wrapped_q     <= wrapped_d;
      overrun_q     <= overrun_d;
      load_done_q   <= load_done_d;
      mem_address_q <= mem_address_d;
      mem_be_q      <= mem_be_d;
      mem_cs_q      <= mem_cs_d;
      mem_we_q      <= mem_we_d;
      mem_wd_q      <= mem_wd_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
    end
  end

endmodule

// File: tb/tb_final_soc_mem_loader.sv
// Directed bench for final_soc_mem_loader with a behavioural 4-word memory.
module tb_final_soc_mem_loader;
  import final_soc_mem_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid, in_ready, in_last;
  logic        load_done, overrun;
  logic        rd_start, rd_busy;
  logic [31:0] out_data;
  logic        out_valid, out_ready, out_last;

  int checks = 0;
  int errors = 0;

  logic [31:0] tbmem [DEPTH];

  final_soc_mem_loader_if mif ();

  final_soc_mem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .load_done (load_done),
    .overrun   (overrun),
    .rd_start  (rd_start),
    .rd_busy   (rd_busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .mem       (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: byte-enabled write on the edge, read data one cycle after the address.
  always @(posedge clk) begin
    logic [31:0] m;
    m = {{8{mif.mem_byteenable[3]}}, {8{mif.mem_byteenable[2]}},
         {8{mif.mem_byteenable[1]}}, {8{mif.mem_byteenable[0]}}};
    if (mif.mem_clken && mif.mem_chipselect) begin
      if (mif.mem_write)
        tbmem[mif.mem_address] <= (tbmem[mif.mem_address] & ~m) | (mif.mem_writedata & m);
      else
        mif.mem_readdata <= tbmem[mif.mem_address];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    rd_start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Present one byte, wait (bounded) for in_ready, return just after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_write(input string tag, input int addr, input logic [31:0] wd,
                             input logic [3:0] be);
    chk({tag, ".we"},   32'(mif.mem_write), 32'd1);
    chk({tag, ".cs"},   32'(mif.mem_chipselect), 32'd1);
    chk({tag, ".addr"}, 32'(mif.mem_address), 32'(addr));
    chk({tag, ".wd"},   mif.mem_writedata, wd);
    chk({tag, ".be"},   32'(mif.mem_byteenable), 32'(be));
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, ".load_done"}, 32'(load_done), 32'd0);
    chk({tag, ".overrun"},   32'(overrun), 32'd0);
    chk({tag, ".rd_busy"},   32'(rd_busy), 32'd0);
    chk({tag, ".out_data"},  out_data, 32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_last"},  32'(out_last), 32'd0);
    chk({tag, ".addr"},      32'(mif.mem_address), 32'd0);
    chk({tag, ".be"},        32'(mif.mem_byteenable), 32'd0);
    chk({tag, ".cs"},        32'(mif.mem_chipselect), 32'd0);
    chk({tag, ".we"},        32'(mif.mem_write), 32'd0);
    chk({tag, ".wd"},        mif.mem_writedata, 32'd0);
    chk({tag, ".clken"},     32'(mif.mem_clken), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    rd_start = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check_reset_outs("rst");
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle.in_ready", 32'(in_ready), 32'd1);

    // Full word
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    check_write("t1", 0, 32'h44332211, 4'hF);
    chk("t1.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t1.we_drop", 32'(mif.mem_write), 32'd0);
    chk("t1.mem0", tbmem[0], 32'h44332211);
    chk("t1.load_done", 32'(load_done), 32'd0);

    // Partial flush
    do_reset();
    send_byte(8'hA0, 1'b0); send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0); send_byte(8'hA3, 1'b0);
    check_write("t2a", 0, 32'hA3A2A1A0, 4'hF);
    send_byte(8'hA4, 1'b0); send_byte(8'hA5, 1'b1);
    check_write("t2b", 1, 32'h0000A5A4, 4'b0011);
    chk("t2.ld_early", 32'(load_done), 32'd0);
    tick();
    chk("t2.ld_pulse", 32'(load_done), 32'd1);
    tick();
    chk("t2.ld_clear", 32'(load_done), 32'd0);
    send_byte(8'hB0, 1'b1);
    check_write("t2c", 0, 32'h000000B0, 4'b0001);
    tick();
    chk("t2c.ld_pulse", 32'(load_done), 32'd1);

    // Wrap and overrun
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i + 1), 1'b0);
      if (i % 4 == 3) begin
        chk("t3.we", 32'(mif.mem_write), 32'd1);
        chk("t3.addr", 32'(mif.mem_address), 32'((i / 4) % 4));
      end
      if (i == 15) chk("t3.ovr16", 32'(overrun), 32'd0);
      if (i == 16) chk("t3.ovr17", 32'(overrun), 32'd1);
    end
    chk("t3.wrapdata", mif.mem_writedata, 32'h14131211);
    tick();
    chk("t3.ovr_hold", 32'(overrun), 32'd1);
    send_byte(8'hEE, 1'b1);
    check_write("t3e", 1, 32'h000000EE, 4'b0001);
    chk("t3.ovr_pre", 32'(overrun), 32'd1);
    tick();
    chk("t3.ld", 32'(load_done), 32'd1);
    chk("t3.ovr_clr", 32'(overrun), 32'd0);

    // Preload 1,2,3,4 then read back with backpressure
    do_reset();
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++)
        send_byte((b == 0) ? 8'(w + 1) : 8'h00, (w == 3) && (b == 3));
    tick();
    chk("t4.ld", 32'(load_done), 32'd1);
    tick();
    for (int w = 0; w < 4; w++) chk("t4.mem", tbmem[w], 32'(w + 1));
    rd_start = 1'b1;
    #1;
    chk("t4.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rd_start = 1'b0;
    chk("t4.busy", 32'(rd_busy), 32'd1);
    chk("t4.cs", 32'(mif.mem_chipselect), 32'd1);
    chk("t4.we", 32'(mif.mem_write), 32'd0);
    chk("t4.addr0", 32'(mif.mem_address), 32'd0);
    tick();
    chk("t4.ov_n2", 32'(out_valid), 32'd0);
    tick();
    chk("t4.ov1", 32'(out_valid), 32'd1);
    chk("t4.d1", out_data, 32'd1);
    chk("t4.l1", 32'(out_last), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("t4.ov_drop", 32'(out_valid), 32'd0);
    chk("t4.addr1", 32'(mif.mem_address), 32'd1);
    tick(); tick();
    chk("t4.d2", out_data, 32'd2);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4.hold_v", 32'(out_valid), 32'd1);
      chk("t4.hold_d", out_data, 32'd2);
    end
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t4.d3", out_data, 32'd3);
    chk("t4.l3", 32'(out_last), 32'd0);
    tick(); tick(); tick();
    chk("t4.d4", out_data, 32'd4);
    chk("t4.l4", 32'(out_last), 32'd1);
    chk("t4.busy4", 32'(rd_busy), 32'd1);
    tick();
    chk("t4.busy_end", 32'(rd_busy), 32'd0);
    chk("t4.ov_end", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Arbitration: rd_start ignored mid-word
    send_byte(8'hC1, 1'b0); send_byte(8'hC2, 1'b0);
    rd_start = 1'b1;
    #1;
    chk("t5.in_ready", 32'(in_ready), 32'd1);
    tick();
    rd_start = 1'b0;
    chk("t5.busy_ign", 32'(rd_busy), 32'd0);
    chk("t5.cs_ign", 32'(mif.mem_chipselect), 32'd0);
    send_byte(8'hC3, 1'b0); send_byte(8'hC4, 1'b1);
    check_write("t5c", 0, 32'hC4C3C2C1, 4'hF);
    tick(); tick();
    // Arbitration: rd_start beats a simultaneous byte
    in_data = 8'h5A; in_valid = 1'b1; rd_start = 1'b1;
    #1;
    chk("t5.race_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; rd_start = 1'b0;
    chk("t5.race_busy", 32'(rd_busy), 32'd1);
    chk("t5.race_we", 32'(mif.mem_write), 32'd0);
    tick(); tick();
    chk("t5.rd0", out_data, 32'hC4C3C2C1);
    out_ready = 1'b1;
    n = 0;
    while (rd_busy && n < 40) begin tick(); n++; end
    chk("t5.rd_end", 32'(rd_busy), 32'd0);
    out_ready = 1'b0;
    send_byte(8'hD1, 1'b0); send_byte(8'hD2, 1'b0);
    send_byte(8'hD3, 1'b0); send_byte(8'hD4, 1'b0);
    check_write("t5d", 0, 32'hD4D3D2D1, 4'hF);
    tick();

    // Reset with three bytes pending
    send_byte(8'hE1, 1'b0); send_byte(8'hE2, 1'b0); send_byte(8'hE3, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6a.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check_reset_outs("t6a");
    reset = 1'b0;
    tick();
    chk("t6a.we", 32'(mif.mem_write), 32'd0);
    chk("t6a.mem0", tbmem[0], 32'hD4D3D2D1);
    chk("t6a.mem1", tbmem[1], 32'd2);
    chk("t6a.mem2", tbmem[2], 32'd3);
    chk("t6a.mem3", tbmem[3], 32'd4);
    send_byte(8'hF1, 1'b0); send_byte(8'hF2, 1'b0);
    send_byte(8'hF3, 1'b0); send_byte(8'hF4, 1'b0);
    check_write("t6f", 0, 32'hF4F3F2F1, 4'hF);
    tick();

    // Reset during RD_OUT
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    tick(); tick();
    chk("t6b.ov", 32'(out_valid), 32'd1);
    chk("t6b.d0", out_data, 32'hF4F3F2F1);
    reset = 1'b1;
    tick();
    check_reset_outs("t6b");
    reset = 1'b0;
    tick();
    chk("t6b.ov_after", 32'(out_valid), 32'd0);
    chk("t6b.we_after", 32'(mif.mem_write), 32'd0);
    chk("t6b.busy_after", 32'(rd_busy), 32'd0);
    chk("t6b.mem0", tbmem[0], 32'hF4F3F2F1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
